// File: rtl/sysid_access_ctrl.sv
// sysid_access_ctrl
//   Boot-time check of the system-ID slave followed by round-robin sharing of
//   its single-word read port between two requesters.
//
//   Optional feature macro: SYSID_BOOT_CHECK_EN
//     defined   : after reset, address 0 (ID) and address 1 (timestamp) are read
//                 and compared against EXPECT_ID / EXPECT_TS before arbitration starts.
//     undefined : arbitration starts straight out of reset, boot_done_o goes high
//                 on the first edge, id_ok_o / id_mismatch_o stay 0.
//
//   Ports
//     clock_i           system clock (rising edge)
//     reset_n_i         asynchronous active-low reset
//     sysid_address_o   word address to the system-ID slave
//     sysid_readdata_i  read data from the slave, READ_LATENCY cycles after address
//     req_i[1:0]        per-requester read request, held until granted
//     req_addr_i[1:0]   per-requester word select, sampled on the grant edge
//     gnt_o[1:0]        one-hot single-cycle grant (ISSUE cycle)
//     rvalid_o[1:0]     one-hot single-cycle read-data valid (RESP cycle)
//     rdata_o[31:0]     last sampled read data
//     boot_done_o       boot check finished (sticky)
//     id_ok_o           both boot words matched (sticky)
//     id_mismatch_o     at least one boot word differed (sticky)
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   BOOT_ID | boot read of address 0, READ_LATENCY+2 cycles
//   BOOT_TS | boot read of address 1, flags set on its last edge
//   IDLE    | arbitrate between pending requests
//   ISSUE   | grant pulse, address driven
//   WAIT    | slave latency, readdata sampled on the last WAIT edge
//   RESP    | rvalid pulse with rdata

module sysid_access_ctrl #(
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] EXPECT_ID    = 32'd0,
  parameter logic [31:0] EXPECT_TS    = 32'd1370770100
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  output logic        sysid_address_o,
  input  logic [31:0] sysid_readdata_i,
  input  logic [1:0]  req_i,
  input  logic [1:0]  req_addr_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  rvalid_o,
  output logic [31:0] rdata_o,
  output logic        boot_done_o,
  output logic        id_ok_o,
  output logic        id_mismatch_o
);

  typedef enum logic [2:0] {
    S_BOOT_ID, S_BOOT_TS, S_IDLE, S_ISSUE, S_WAIT, S_RESP
  } state_e;

  // One down-counter paces every read: loaded with READ_LATENCY+1 on the
  // issue cycle, data is sampled at count 1 and boot reads finish at count 0.
  localparam logic [2:0] CNT_LOAD = 3'(READ_LATENCY + 1);

`ifdef SYSID_BOOT_CHECK_EN
  localparam state_e RESET_STATE = S_BOOT_ID;
`else
  localparam state_e RESET_STATE = S_IDLE;
`endif

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        addr_q, addr_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic        win_q, win_d;
  logic        last_q, last_d;
  logic [31:0] rdata_q, rdata_d;
  logic        boot_done_q, boot_done_d;
  logic        sample;
  logic        pick;

`ifdef SYSID_BOOT_CHECK_EN
  logic id_match_q, id_match_d;
  logic ts_match_q, ts_match_d;
  logic id_ok_q, id_ok_d;
  logic id_mis_q, id_mis_d;
`else
  logic unused_expect;
  assign unused_expect = ^{EXPECT_ID, EXPECT_TS};
`endif

  assign sample = (cnt_q == 3'd1);
  // With both requesting, the one not granted last wins; last_q resets to 1
  // so requester 0 is favoured first.
  assign pick   = (req_i == 2'b11) ? ~last_q : req_i[1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    gnt_d       = 2'b00;
    rvalid_d    = 2'b00;
    win_d       = win_q;
    last_d      = last_q;
    rdata_d     = rdata_q;
    boot_done_d = boot_done_q;
`ifdef SYSID_BOOT_CHECK_EN
    id_match_d  = id_match_q;
    ts_match_d  = ts_match_q;
    id_ok_d     = id_ok_q;
    id_mis_d    = id_mis_q;
`else
    boot_done_d = 1'b1;
`endif
    case (state_q)
`ifdef SYSID_BOOT_CHECK_EN
      S_BOOT_ID: begin
        cnt_d = cnt_q - 3'd1;
        if (sample) id_match_d = (sysid_readdata_i == EXPECT_ID);
        if (cnt_q == 3'd0) begin
          state_d = S_BOOT_TS;
          cnt_d   = CNT_LOAD;
          addr_d  = 1'b1;
        end
      end
      S_BOOT_TS: begin
        cnt_d = cnt_q - 3'd1;
        if (sample) ts_match_d = (sysid_readdata_i == EXPECT_TS);
        if (cnt_q == 3'd0) begin
          state_d     = S_IDLE;
          addr_d      = 1'b0;
          boot_done_d = 1'b1;
          id_ok_d     = id_match_q & ts_match_q;
          id_mis_d    = ~(id_match_q & ts_match_q);
        end
      end
`endif
      S_IDLE: begin
        if (req_i != 2'b00) begin
          state_d = S_ISSUE;
          cnt_d   = CNT_LOAD;
          gnt_d   = pick ? 2'b10 : 2'b01;
          addr_d  = req_addr_i[pick];
          win_d   = pick;
          last_d  = pick;
        end
      end
      S_ISSUE, S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (sample) begin
          state_d  = S_RESP;
          rdata_d  = sysid_readdata_i;
          rvalid_d = win_q ? 2'b10 : 2'b01;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        addr_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= RESET_STATE;
      cnt_q       <= CNT_LOAD;
      addr_q      <= 1'b0;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      win_q       <= 1'b0;
      last_q      <= 1'b1;
      rdata_q     <= 32'd0;
      boot_done_q <= 1'b0;
`ifdef SYSID_BOOT_CHECK_EN
      id_match_q  <= 1'b0;
      ts_match_q  <= 1'b0;
      id_ok_q     <= 1'b0;
      id_mis_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      win_q       <= win_d;
      last_q      <= last_d;
      rdata_q     <= rdata_d;
      boot_done_q <= boot_done_d;
`ifdef SYSID_BOOT_CHECK_EN
      id_match_q  <= id_match_d;
      ts_match_q  <= ts_match_d;
      id_ok_q     <= id_ok_d;
      id_mis_q    <= id_mis_d;
`endif
    end
  end

  assign sysid_address_o = addr_q;
  assign gnt_o           = gnt_q;
  assign rvalid_o        = rvalid_q;
  assign rdata_o         = rdata_q;
  assign boot_done_o     = boot_done_q;
`ifdef SYSID_BOOT_CHECK_EN
  assign id_ok_o         = id_ok_q;
  assign id_mismatch_o   = id_mis_q;
`else
  assign id_ok_o         = 1'b0;
  assign id_mismatch_o   = 1'b0;
`endif

endmodule
